// File: rtl/fpu_div16.sv
// FP16 (IEEE-754 binary16) sequential divider coprocessor, round-to-nearest-even.
// Restoring significand divider, one quotient bit per cycle, constant latency
// for every operand class. Result/flag/condition-code contract matches the
// FP16 multiplier coprocessor so both can share the FPU output mux.
module fpu_div16 #(
  parameter int QBITS = 14
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] fpuIn1,
  input  logic [15:0] fpuIn2,
  output logic [15:0] fpuOut,
  output logic        done,
  output logic [3:0]  condCodes,
  output logic [4:0]  opStatusFlags
);

  localparam int CW = $clog2(QBITS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_ROUND = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [15:0]       r_a, r_b;
  logic [10:0]       r_sig_a, r_sig_b;
  logic signed [7:0] r_exp;
  logic              r_sign;
  logic              r_spec;
  logic [15:0]       r_spec_res;
  logic [4:0]        r_spec_flags;
  logic [12:0]       r_rem;
  logic [QBITS-1:0]  r_q;
  logic [CW-1:0]     r_cnt;
  logic [15:0]       r_out;
  logic [4:0]        r_flags;
  logic [3:0]        r_cc;
  logic              r_done;

  // Leading-zero count of an 11-bit significand (11 when all zero).
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i <= 10; i++)
      if (v[i]) lzc11 = 4'(10 - i);
  endfunction

  // Operand classification, denormal normalisation and special-case resolution.
  logic              w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
  logic [3:0]        w_lz_a, w_lz_b;
  logic [10:0]       w_sig_a, w_sig_b;
  logic signed [7:0] w_eff_a, w_eff_b, w_exp_res;
  logic              w_sign, w_spec;
  logic [15:0]       w_spec_res;
  logic [4:0]        w_spec_flags;

  // Combinational PREP-stage decode of the latched operands.
  always_comb begin
    w_a_zero = (r_a[14:10] == 5'd0)  && (r_a[9:0] == 10'd0);
    w_a_inf  = (r_a[14:10] == 5'd31) && (r_a[9:0] == 10'd0);
    w_a_nan  = (r_a[14:10] == 5'd31) && (r_a[9:0] != 10'd0);
    w_b_zero = (r_b[14:10] == 5'd0)  && (r_b[9:0] == 10'd0);
    w_b_inf  = (r_b[14:10] == 5'd31) && (r_b[9:0] == 10'd0);
    w_b_nan  = (r_b[14:10] == 5'd31) && (r_b[9:0] != 10'd0);
    w_lz_a   = lzc11({1'b0, r_a[9:0]});
    w_lz_b   = lzc11({1'b0, r_b[9:0]});
    if (r_a[14:10] == 5'd0) begin
      w_sig_a = {1'b0, r_a[9:0]} << w_lz_a;
      w_eff_a = 8'sd1 - $signed({4'b0, w_lz_a});
    end else begin
      w_sig_a = {1'b1, r_a[9:0]};
      w_eff_a = $signed({3'b0, r_a[14:10]});
    end
    if (r_b[14:10] == 5'd0) begin
      w_sig_b = {1'b0, r_b[9:0]} << w_lz_b;
      w_eff_b = 8'sd1 - $signed({4'b0, w_lz_b});
    end else begin
      w_sig_b = {1'b1, r_b[9:0]};
      w_eff_b = $signed({3'b0, r_b[14:10]});
    end
    w_exp_res    = w_eff_a - w_eff_b + 8'sd15;
    w_sign       = r_a[15] ^ r_b[15];
    w_spec       = 1'b0;
    w_spec_res   = 16'h0000;
    w_spec_flags = 5'b00000;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec = 1'b1; w_spec_res = 16'h7E00; w_spec_flags = 5'b10000;
    end else if (w_a_inf) begin
      w_spec = 1'b1; w_spec_res = {w_sign, 15'h7C00};
    end else if (w_b_zero) begin
      w_spec = 1'b1; w_spec_res = {w_sign, 15'h7C00}; w_spec_flags = 5'b01000;
    end else if (w_b_inf || w_a_zero) begin
      w_spec = 1'b1; w_spec_res = {w_sign, 15'h0000};
    end
  end

  // One restoring-division step: trial subtract, keep or restore, shift.
  logic [13:0] w_diff;
  logic        w_borrow;
  logic [12:0] w_rem_sel;
  always_comb begin
    w_diff    = {1'b0, r_rem} - {3'b000, r_sig_b};
    w_borrow  = w_diff[13];
    w_rem_sel = w_borrow ? r_rem : w_diff[12:0];
  end

  // Normalise quotient, denormalise if tiny, round to nearest even, pack.
  logic [QBITS-1:0]  w_qn;
  logic signed [7:0] w_en, w_ef;
  logic [10:0]       w_sig0, w_sig;
  logic              w_g0, w_st0, w_g, w_st, w_tiny, w_inexact, w_up, w_ovf;
  logic [3:0]        w_sh;
  logic [23:0]       w_v;
  logic [11:0]       w_sum;
  logic [9:0]        w_mant;
  logic [15:0]       w_res;
  logic [4:0]        w_flags;
  always_comb begin
    w_qn   = r_q[QBITS-1] ? r_q : (r_q << 1);
    w_en   = r_q[QBITS-1] ? r_exp : (r_exp - 8'sd1);
    w_sig0 = w_qn[QBITS-1 -: 11];
    w_g0   = w_qn[QBITS-12];
    w_st0  = (|w_qn[QBITS-13:0]) | (r_rem != 13'd0);
    w_tiny = (w_en <= 8'sd0);
    w_sh   = 4'd0;
    if (w_tiny) w_sh = (w_en < -8'sd11) ? 4'd12 : 4'(8'sd1 - w_en);
    w_v       = {w_sig0, w_g0, 12'b0} >> w_sh;
    w_sig     = w_v[23:13];
    w_g       = w_v[12];
    w_st      = w_st0 | (|w_v[11:0]);
    w_inexact = w_g | w_st;
    w_up      = w_g & (w_st | w_sig[0]);
    w_sum     = {1'b0, w_sig} + {11'b0, w_up};
    if (w_tiny) begin
      w_ef   = w_sum[10] ? 8'sd1 : 8'sd0;
      w_mant = w_sum[9:0];
    end else if (w_sum[11]) begin
      w_ef   = w_en + 8'sd1;
      w_mant = w_sum[10:1];
    end else begin
      w_ef   = w_en;
      w_mant = w_sum[9:0];
    end
    w_ovf   = !w_tiny && (w_ef >= 8'sd31);
    w_res   = w_ovf ? {r_sign, 5'h1F, 10'h000} : {r_sign, w_ef[4:0], w_mant};
    w_flags = {2'b00, w_ovf, w_tiny & w_inexact, w_inexact | w_ovf};
    if (r_spec) begin
      w_res   = r_spec_res;
      w_flags = r_spec_flags;
    end
  end

  logic w_accept;
  assign w_accept = start && ((r_state == S_IDLE) || ((r_state == S_DONE) && r_done));

  // Control FSM plus datapath registers.
  // NOTE: only control and visible outputs are reset; the datapath registers
  // are always rewritten before use, so resetting them would add no safety.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_out   <= 16'h0000;
      r_done  <= 1'b0;
      r_cc    <= 4'h0;
      r_flags <= 5'h00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= (r_state == S_DONE) && !w_accept;
          if (w_accept) begin
            r_a     <= fpuIn1;
            r_b     <= fpuIn2;
            r_flags <= 5'h00;
            r_cc    <= 4'h0;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_sig_a      <= w_sig_a;
          r_sig_b      <= w_sig_b;
          r_exp        <= w_exp_res;
          r_sign       <= w_sign;
          r_spec       <= w_spec;
          r_spec_res   <= w_spec_res;
          r_spec_flags <= w_spec_flags;
          r_rem        <= {2'b00, w_sig_a};
          r_q          <= '0;
          r_cnt        <= '0;
          r_state      <= S_DIV;
        end
        S_DIV: begin
          r_rem <= w_rem_sel << 1;
          r_q   <= {r_q[QBITS-2:0], ~w_borrow};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(QBITS - 1)) r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_out   <= w_res;
          r_flags <= w_flags;
          r_cc    <= {(w_res[14:0] == 15'd0), 1'b0, w_res[15], w_flags[2]};
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fpuOut        = r_out;
  assign done          = r_done;
  assign condCodes     = r_cc;
  assign opStatusFlags = r_flags;

endmodule

// File: tb/tb_fpu_div16.sv
// Self-checking bench for fpu_div16: scoreboard of expected results, latency
// and handshake checks, specials, range corners, mid-operation reset.
module tb_fpu_div16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] fpuIn1, fpuIn2, fpuOut;
  logic        done;
  logic [3:0]  condCodes;
  logic [4:0]  opStatusFlags;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [15:0] out;
    logic [4:0]  flags;
    logic [3:0]  cc;
  } exp_t;

  exp_t sb[$];

  fpu_div16 dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .fpuIn1       (fpuIn1),
    .fpuIn2       (fpuIn2),
    .fpuOut       (fpuOut),
    .done         (done),
    .condCodes    (condCodes),
    .opStatusFlags(opStatusFlags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one division, push its expectation, then wait for done and score it.
  // hold = number of cycles start stays high after acceptance.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_out, input logic [4:0] exp_fl, input int hold);
    exp_t e;
    exp_t p;
    int   lat;
    bit   got;
    e.tag   = tag;
    e.out   = exp_out;
    e.flags = exp_fl;
    e.cc    = {(exp_out[14:0] == 15'd0), 1'b0, exp_out[15], exp_fl[2]};
    sb.push_back(e);
    @(negedge clock);
    fpuIn1 = a;
    fpuIn2 = b;
    start  = 1'b1;
    @(posedge clock);
    #1;
    check({tag, "_done_low_after_accept"}, done, 0);
    fpuIn1 = 16'($urandom);
    fpuIn2 = 16'($urandom);
    if (hold == 0) start = 1'b0;
    lat = 0;
    got = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clock);
      #1;
      if (i >= hold) start = 1'b0;
      if (done) begin
        got = 1;
        lat = i;
      end
    end
    check({tag, "_latency"}, lat, 17);
    p = sb.pop_front();
    check({p.tag, "_out"}, fpuOut, p.out);
    check({p.tag, "_flags"}, opStatusFlags, p.flags);
    check({p.tag, "_cc"}, condCodes, p.cc);
  endtask

  initial begin
    int bad;
    reset  = 1'b0;
    start  = 1'b0;
    fpuIn1 = 16'h0;
    fpuIn2 = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out", fpuOut, 16'h0000);
    check("rst_done", done, 0);
    check("rst_cc", condCodes, 0);
    check("rst_flags", opStatusFlags, 0);
    @(negedge clock);
    reset = 1'b1;

    // 1/1 and output hold for 20 cycles
    do_op("one_div_one", 16'h3C00, 16'h3C00, 16'h3C00, 5'b00000, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (!done || fpuOut !== 16'h3C00) bad++;
    end
    check("done_hold_20", bad, 0);

    // 1/3 then back-to-back 6/-2 started from DONE
    do_op("one_div_three", 16'h3C00, 16'h4200, 16'h3555, 5'b00001, 0);
    do_op("six_div_m2", 16'h4600, 16'hC000, 16'hC200, 5'b00000, 0);

    // specials
    do_op("one_div_zero", 16'h3C00, 16'h0000, 16'h7C00, 5'b01000, 0);
    do_op("zero_div_zero", 16'h0000, 16'h0000, 16'h7E00, 5'b10000, 0);
    do_op("inf_div_inf", 16'h7C00, 16'h7C00, 16'h7E00, 5'b10000, 0);
    do_op("zero_div_m2", 16'h0000, 16'hC000, 16'h8000, 5'b00000, 0);
    do_op("nan_div_one", 16'h7E01, 16'h3C00, 16'h7E00, 5'b10000, 0);
    do_op("inf_div_m1", 16'h7C00, 16'hBC00, 16'hFC00, 5'b00000, 0);

    // range corners
    do_op("max_div_min", 16'h7BFF, 16'h0001, 16'h7C00, 5'b00101, 0);
    do_op("minnorm_div2", 16'h0400, 16'h4000, 16'h0200, 5'b00000, 0);
    do_op("mindenorm_div2", 16'h0001, 16'h4000, 16'h0000, 5'b00011, 0);

    // reset in the middle of a 1/3 divide
    @(negedge clock);
    fpuIn1 = 16'h3C00;
    fpuIn2 = 16'h4200;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_out", fpuOut, 16'h0000);
    check("midrst_done", done, 0);
    check("midrst_cc", condCodes, 0);
    check("midrst_flags", opStatusFlags, 0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (done) bad++;
    end
    check("midrst_no_result", bad, 0);
    do_op("after_rst_one_div_three", 16'h3C00, 16'h4200, 16'h3555, 5'b00001, 0);

    // start held high through DIVIDE, operands scrambled after acceptance
    do_op("held_start_six_div_two", 16'h4600, 16'h4000, 16'h4200, 5'b00000, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
